button_overlay: RTL and testbench

BUTTON_OVERLAY -- requirements
Module: button_overlay

---
 rtl/button_overlay_pkg.sv | 30 +++
 rtl/button_overlay_press_stretch.sv | 42 ++++
 rtl/button_overlay.sv | 104 ++++++++++
 tb/tb_button_overlay.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_overlay_pkg.sv
// Shared defaults and channel indices for the button sprite overlay.
package button_overlay_pkg;

    localparam int COORD_W_DEF  = 10;
    localparam int RGB_W_DEF    = 12;
    localparam int NUM_BTNS_DEF = 12;

    // Bit i set: channel i treats an all-ones pixel as transparent, else all-zeros.
    localparam logic [15:0] KEY_SEL_DEF = 16'b0000_0000_1000_0011;

    typedef enum logic [3:0] {
        BTN_A      = 4'd0,
        BTN_B      = 4'd1,
        BTN_X      = 4'd2,
        BTN_Y      = 4'd3,
        BTN_START  = 4'd4,
        BTN_L      = 4'd5,
        BTN_R      = 4'd6,
        BTN_Z      = 4'd7,
        BTN_DUP    = 4'd8,
        BTN_DDOWN  = 4'd9,
        BTN_DRIGHT = 4'd10,
        BTN_DLEFT  = 4'd11
    } btn_idx_e;

    function automatic int hold_cnt_w(input int hold_frames);
        return (hold_frames < 1) ? 1 : $clog2(hold_frames + 1);
    endfunction

endpackage

// File: rtl/button_overlay_press_stretch.sv
// One button channel: two-flop synchroniser and a frame-based hold counter
// that keeps the channel lit for HOLD_FRAMES frames after release.
module press_stretch
    import button_overlay_pkg::*;
#(
    parameter int HOLD_FRAMES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic btn_raw,
    output logic btn_lit
);

    localparam int CNT_W = hold_cnt_w(HOLD_FRAMES);

    logic             btn_meta;
    logic             btn_sync;
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            hold_cnt <= '0;
            btn_lit  <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            if (frame_start) begin
                if (btn_sync) begin
                    hold_cnt <= CNT_W'(HOLD_FRAMES);
                end else if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - CNT_W'(1);
                end
            end
            // Lags the counter by one cycle so the frame_start pixel sees the old state.
            btn_lit <= (hold_cnt != '0);
        end
    end

endmodule

// File: rtl/button_overlay.sv
// Button sprite overlay: windowed ROM addressing, per-channel lit state and
// a two-stage priority compositor (lowest opaque channel wins).
module button_overlay
    import button_overlay_pkg::*;
#(
    parameter int                  NUM_BTNS    = NUM_BTNS_DEF,
    parameter int                  COORD_W     = COORD_W_DEF,
    parameter int                  RGB_W       = RGB_W_DEF,
    parameter int                  HOLD_FRAMES = 4,
    parameter logic [NUM_BTNS-1:0] KEY_SEL     = NUM_BTNS'(KEY_SEL_DEF)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic [COORD_W-1:0]        x_pos,
    input  logic [COORD_W-1:0]        y_pos,
    input  logic [COORD_W-1:0]        size_x,
    input  logic [COORD_W-1:0]        size_y,
    input  logic [NUM_BTNS-1:0]       btn_raw,
    input  logic [NUM_BTNS*RGB_W-1:0] rom_rgb,
    output logic [COORD_W-1:0]        row,
    output logic [COORD_W-1:0]        col,
    output logic [NUM_BTNS-1:0]       btn_lit,
    output logic                      overlay_on,
    output logic [RGB_W-1:0]          overlay_rgb
);

    function automatic logic is_key(input logic [RGB_W-1:0] pix, input logic key_ones);
        return key_ones ? (&pix) : ~(|pix);
    endfunction

    logic [COORD_W:0]     x_end;
    logic [COORD_W:0]     y_end;
    logic                 in_win_p0;
    logic                 in_win_p1;
    logic                 vld_p1;
    logic [NUM_BTNS-1:0]  opaque;
    logic                 any_opaque;
    logic [RGB_W-1:0]     win_rgb;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        press_stretch #(
            .HOLD_FRAMES(HOLD_FRAMES)
        ) u_stretch (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_start(frame_start),
            .btn_raw    (btn_raw[i]),
            .btn_lit    (btn_lit[i])
        );
    end

    assign row = y - y_pos;
    assign col = x - x_pos;

    // Window end computed one bit wider so a window running off the right/bottom clips instead of wrapping.
    assign x_end     = {1'b0, x_pos} + {1'b0, size_x};
    assign y_end     = {1'b0, y_pos} + {1'b0, size_y};
    assign in_win_p0 = (x >= x_pos) && ({1'b0, x} < x_end) &&
                       (y >= y_pos) && ({1'b0, y} < y_end);

    // ---- stage 1: window flag travels alongside the ROM read ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_win_p1 <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            in_win_p1 <= in_win_p0;
            vld_p1    <= 1'b1;
        end
    end

    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            opaque[i] = btn_lit[i] && !is_key(rom_rgb[i*RGB_W +: RGB_W], KEY_SEL[i]);
        end
    end

    always_comb begin
        any_opaque = 1'b0;
        win_rgb    = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                any_opaque = 1'b1;
                win_rgb    = rom_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    // ---- stage 2: composite and register outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overlay_on  <= 1'b0;
            overlay_rgb <= '0;
        end else begin
            overlay_on  <= vld_p1 && in_win_p1 && any_opaque;
            overlay_rgb <= (vld_p1 && in_win_p1 && any_opaque) ? win_rgb : '0;
        end
    end

endmodule

// File: tb/tb_button_overlay.sv
// Scoreboard bench for button_overlay with a frame-level reference model.
`timescale 1ns/1ps
module tb_button_overlay;

    localparam int NB = 12;
    localparam int CW = 10;
    localparam int RW = 12;
    localparam int HOLD = 4;
    localparam logic [NB-1:0] KSEL = 12'b0000_1000_0011;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_start;
    logic [CW-1:0] x, y, x_pos, y_pos, size_x, size_y;
    logic [NB-1:0] btn_raw;
    logic [NB*RW-1:0] rom_rgb;
    logic [CW-1:0] row, col;
    logic [NB-1:0] btn_lit;
    logic overlay_on;
    logic [RW-1:0] overlay_rgb;

    always #5 clk = ~clk;

    button_overlay dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .x(x), .y(y), .x_pos(x_pos), .y_pos(y_pos), .size_x(size_x), .size_y(size_y),
        .btn_raw(btn_raw), .rom_rgb(rom_rgb), .row(row), .col(col),
        .btn_lit(btn_lit), .overlay_on(overlay_on), .overlay_rgb(overlay_rgb)
    );

    typedef struct { int due; int row; int col; } rc_t;
    typedef struct { int due; bit on; int rgb; logic [NB-1:0] lit; } ex_t;

    rc_t rc_q[$];
    ex_t ex_q[$];
    rc_t mrc;
    ex_t mex;
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    // Stimulus-side state; the *_nx copies are applied at the start of each pixel.
    int wxp = 0, wyp = 0, wsx = 0, wsy = 0;
    int wxp_nx = 0, wyp_nx = 0, wsx_nx = 0, wsy_nx = 0;
    logic [NB-1:0] btn_nx = '0;
    bit rom_fixed_mode = 1'b1, rom_fixed_mode_nx = 1'b1;
    logic [RW-1:0] rom_fixed [NB];
    logic [RW-1:0] rom_fixed_nx [NB];

    // Model state: presses seen at the most recent frame starts, raw level history.
    logic [NB-1:0] fs_hist[$];
    logic [NB-1:0] raw_m1 = '0, raw_m2 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] key_of(input int ch);
        return KSEL[ch] ? {RW{1'b1}} : {RW{1'b0}};
    endfunction

    function automatic logic [RW-1:0] rom_fn(input int ch, input int r, input int c);
        if (rom_fixed_mode) return rom_fixed[ch];
        if (((r * 7 + c * 3 + ch * 5) % 5) == 0) return key_of(ch);
        return RW'((r * 37 + c * 11 + ch * 291) & 12'hFFF);
    endfunction

    // Behaves like a synchronous ROM addressed by the DUT's row/col.
    always @(posedge clk) begin
        for (int ch = 0; ch < NB; ch++) rom_rgb[ch*RW +: RW] <= rom_fn(ch, int'(row), int'(col));
    end

    function automatic logic [NB-1:0] recent_press();
        logic [NB-1:0] acc = '0;
        foreach (fs_hist[k]) acc |= fs_hist[k];
        return acc;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic pixel(input int px_in, input int py_in, input bit fs);
        rc_t rc;
        ex_t ex;
        int px, py, mr, mc;
        bit inw, found;
        logic [NB-1:0] lit_s2;
        logic [RW-1:0] pix;
        @(posedge clk);
        #1;
        px = px_in & 1023;
        py = py_in & 1023;
        wxp = wxp_nx; wyp = wyp_nx; wsx = wsx_nx; wsy = wsy_nx;
        rom_fixed_mode = rom_fixed_mode_nx;
        foreach (rom_fixed[k]) rom_fixed[k] = rom_fixed_nx[k];
        x = CW'(px); y = CW'(py); frame_start = fs; btn_raw = btn_nx;
        x_pos = CW'(wxp); y_pos = CW'(wyp); size_x = CW'(wsx); size_y = CW'(wsy);
        mr = (py - wyp) & 1023;
        mc = (px - wxp) & 1023;
        inw = (px >= wxp) && (px < wxp + wsx) && (py >= wyp) && (py < wyp + wsy);
        // A channel shows if a press was seen at any of the last HOLD frame starts before this pixel.
        lit_s2 = recent_press();
        ex.on = 1'b0;
        ex.rgb = 0;
        found = 1'b0;
        for (int ch = 0; ch < NB; ch++) begin
            pix = rom_fn(ch, mr, mc);
            if (!found && inw && lit_s2[ch] && pix != key_of(ch)) begin
                found = 1'b1;
                ex.on = 1'b1;
                ex.rgb = int'(pix);
            end
        end
        if (fs) begin
            fs_hist.push_back(raw_m2);
            if (fs_hist.size() > HOLD) void'(fs_hist.pop_front());
        end
        raw_m2 = raw_m1;
        raw_m1 = btn_nx;
        ex.lit = recent_press();
        ex.due = cyc + 2;
        rc.due = cyc;
        rc.row = mr;
        rc.col = mc;
        rc_q.push_back(rc);
        ex_q.push_back(ex);
    endtask

    task automatic line(input int py, input int x0, input int x1);
        for (int px = x0; px <= x1; px++) pixel(px, py, 1'b0);
    endtask

    task automatic fstart();
        line(10, 0, 3);
        pixel(0, 0, 1'b1);
    endtask

    task automatic set_win(input int xp, input int yp, input int sx, input int sy);
        wxp_nx = xp; wyp_nx = yp; wsx_nx = sx; wsy_nx = sy;
    endtask

    task automatic all_keys();
        for (int ch = 0; ch < NB; ch++) rom_fixed_nx[ch] = key_of(ch);
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3;
        chk("pre_reset_on", overlay_on, 1);
        rst_n = 1'b0;
        #1;
        rc_q.delete();
        ex_q.delete();
        chk("async_rst_on", overlay_on, 0);
        chk("async_rst_rgb", overlay_rgb, 0);
        chk("async_rst_lit", btn_lit, 0);
        frame_start = 1'b0;
        btn_raw = '0;
        fs_hist.delete();
        raw_m1 = '0;
        raw_m2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rc_q.size() > 0 && rc_q[0].due <= cyc) begin
            mrc = rc_q.pop_front();
            if (mrc.due != cyc) chk("rc_sched", cyc, mrc.due);
            chk("row", row, mrc.row);
            chk("col", col, mrc.col);
        end
        if (ex_q.size() > 0 && ex_q[0].due <= cyc) begin
            mex = ex_q.pop_front();
            if (mex.due != cyc) chk("ex_sched", cyc, mex.due);
            chk("overlay_on", overlay_on, mex.on);
            chk("overlay_rgb", overlay_rgb, mex.rgb);
            chk("btn_lit", btn_lit, mex.lit);
        end
    end

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        x = '0; y = '0; x_pos = '0; y_pos = '0; size_x = '0; size_y = '0;
        btn_raw = '0;
        for (int ch = 0; ch < NB; ch++) begin
            rom_fixed[ch] = key_of(ch);
            rom_fixed_nx[ch] = key_of(ch);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("reset_on", overlay_on, 0);
        chk("reset_rgb", overlay_rgb, 0);
        chk("reset_lit", btn_lit, 0);
        #1;
        rst_n = 1'b1;

        // Single channel in a 32x32 window, then an asynchronous reset mid-line.
        set_win(100, 50, 32, 32);
        all_keys();
        rom_fixed_nx[0] = 12'h0F0;
        btn_nx = 12'h001;
        fstart();
        line(60, 90, 140);
        line(60, 95, 110);
        reset_mid();
        line(60, 90, 140);
        fstart();
        line(60, 90, 140);

        // Priority between channels 2 and 5, then channel 2 goes transparent.
        btn_nx = 12'h024;
        all_keys();
        rom_fixed_nx[2] = 12'h0A5;
        rom_fixed_nx[5] = 12'h5A5;
        fstart();
        line(60, 98, 134);
        rom_fixed_nx[2] = 12'h000;
        line(60, 98, 134);

        // Channel 0 showing its all-ones key.
        btn_nx = 12'h001;
        all_keys();
        rom_fixed_nx[0] = 12'hFFF;
        fstart();
        line(60, 98, 134);

        // Press for one frame then release: hold across following frames.
        btn_nx = 12'h008;
        all_keys();
        rom_fixed_nx[3] = 12'h123;
        fstart();
        btn_nx = 12'h000;
        for (int f = 0; f < 6; f++) begin
            line(60, 100, 104);
            pixel(0, 0, 1'b1);
        end

        // Window running off the right edge.
        set_win(1000, 0, 100, 1000);
        btn_nx = 12'h008;
        rom_fixed_nx[3] = 12'h456;
        fstart();
        line(5, 990, 1023);
        line(5, 0, 80);

        // Randomised windows, presses, frame starts and sprite content.
        rom_fixed_mode_nx = 1'b0;
        for (int seg = 0; seg < 8; seg++) begin
            int xp, yp, sx, sy;
            xp = ($urandom_range(0, 2) == 0) ? 1024 - $urandom_range(1, 60) : $urandom_range(0, 1023);
            yp = $urandom_range(0, 1023);
            sx = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 200);
            sy = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 200);
            set_win(xp, yp, sx, sy);
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 24) == 0) btn_nx = btn_nx ^ NB'(1 << $urandom_range(0, NB - 1));
                pixel(xp + $urandom_range(0, sx + 16) - 8, yp + $urandom_range(0, sy + 16) - 8,
                      $urandom_range(0, 39) == 0);
            end
        end

        for (int k = 0; k < 10 && (ex_q.size() > 0 || rc_q.size() > 0); k++) @(posedge clk);
        #2;
        chk("drain_pending", ex_q.size() + rc_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
